// File: rtl/ifetch_pkg.sv
// Shared width defaults and FSM state encoding for the instruction fetch unit.
package ifetch_pkg;

   localparam int unsigned IFETCH_PC_WIDTH    = 4;
   localparam int unsigned IFETCH_INSTR_WIDTH = 16;
   localparam int unsigned IFETCH_FIFO_DEPTH  = 2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StSettle = 2'd2
   } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with push/pop/count and a clear that wins over push and pop.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int unsigned WIDTH = IFETCH_PC_WIDTH + IFETCH_INSTR_WIDTH,
   parameter int unsigned DEPTH = IFETCH_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full, do_push, do_pop;

   assign valid   = (count_q != '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop && valid;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_push && do_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches the instruction at pc_in over a req/ack bus and queues {pc, instr} pairs for decode.
// Define IFETCH_FLUSH_EN to add a flush input that empties the queue and drops an in-flight fetch.
module instruction_fetch_unit
   import ifetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = IFETCH_PC_WIDTH,
   parameter int unsigned INSTR_WIDTH = IFETCH_INSTR_WIDTH,
   parameter int unsigned FIFO_DEPTH  = IFETCH_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
`ifdef IFETCH_FLUSH_EN
   input  logic                   flush,
`endif
   input  logic [PC_WIDTH-1:0]    pc_in,
   output logic                   pc_advance,
   output logic                   mem_req,
   output logic [PC_WIDTH-1:0]    mem_addr,
   input  logic                   mem_ack,
   input  logic [INSTR_WIDTH-1:0] mem_rdata,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [INSTR_WIDTH-1:0] inst_data,
   output logic [PC_WIDTH-1:0]    inst_pc
);

   localparam int unsigned ENTRY_W = PC_WIDTH + INSTR_WIDTH;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

   ifetch_state_e       state_q, state_d;
   logic [PC_WIDTH-1:0] addr_q, addr_d;
   logic                drop_q, drop_d;
   logic                flush_int, discard, space, push;
   logic [CNT_W-1:0]    fifo_count;
   logic [ENTRY_W-1:0]  head;

`ifdef IFETCH_FLUSH_EN
   assign flush_int = flush;
`else
   assign flush_int = 1'b0;
`endif

   // A flushed fetch still has to complete on the bus; its data is thrown away.
   assign discard = drop_q || flush_int;
   assign space   = (fifo_count < CNT_W'(FIFO_DEPTH));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      drop_d     = drop_q;
      push       = 1'b0;
      pc_advance = 1'b0;
      unique case (state_q)
         StIdle, StSettle: begin
            if (space) begin
               state_d = StIssue;
               addr_d  = pc_in;
            end else begin
               state_d = StIdle;
            end
         end
         StIssue: begin
            if (flush_int) begin
               drop_d = 1'b1;
            end
            if (mem_ack) begin
               state_d    = StSettle;
               drop_d     = 1'b0;
               push       = !discard && !reset;
               pc_advance = !discard && !reset;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
      end
   end

   assign mem_req  = (state_q == StIssue);
   assign mem_addr = addr_q;

   ifetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush_int),
      .push  (push),
      .wdata ({addr_q, mem_rdata}),
      .pop   (inst_ready),
      .valid (inst_valid),
      .rdata (head),
      .count (fifo_count)
   );

   assign inst_pc   = head[ENTRY_W-1 -: PC_WIDTH];
   assign inst_data = head[INSTR_WIDTH-1:0];

endmodule
